// File: rtl/mips_defs.sv
// mips_defs: encodings shared between the single-cycle and multicycle MIPS
// control units.
//   - opcode / funct values of the supported instruction subset
//   - multicycle FSM state codes (visible on the debug 'state' port)
//   - RegDst, MemToReg, ALUSrcB, ALUOp and PCSource field encodings
//   - ctl_t: the bundle of control strobes one FSM state produces
package mips_defs;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;

  // R-type funct values (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_HALT     = 4'd14
  } state_t;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [2:0] MEMTOREG_ALUOUT = 3'b000;
  localparam logic [2:0] MEMTOREG_MDR    = 3'b001;
  localparam logic [2:0] MEMTOREG_PC     = 3'b010;

  localparam logic [1:0] ALUSRCB_RT      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ANDI  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_not;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [2:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  // States that talk to memory and therefore honour the wait-state window
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// mem_wait_ctr: 4-bit memory wait-state down-counter.
//   clk      rising-edge clock
//   reset    synchronous active-high; loads load_val
//   load     reload with load_val (entry into a memory state)
//   dec      count down while non-zero
//   load_val reload value (number of extra stall cycles)
//   done     count has reached zero, the memory access may complete
module mem_wait_ctr (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != 4'd0)) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign done = (count_reg == 4'd0);

endmodule

// File: rtl/control_multicycle.sv
// control_multicycle: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB for the
// shared multicycle MIPS datapath, one datapath action per cycle.
//   clk, reset        clock, synchronous active-high reset
//   opcode, funct     IR fields, only looked at in DECODE (then latched)
//   PCWrite .. PCSource  datapath control strobes / selects
//   illegal           sticky flag, set when DECODE hits an unsupported opcode
//   state             current state code for debug visibility
// Parameters: MEM_WAIT extra stall cycles per memory state (0..15),
//             ENABLE_JR decodes R-type funct 001000 as JR.
module control_multicycle
  import mips_defs::*;
#(
  parameter int MEM_WAIT  = 0,
  parameter bit ENABLE_JR = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNot,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [2:0] MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t     state_reg, state_next;
  logic [5:0] op_reg, funct_reg;
  logic       illegal_reg;
  logic       wait_done;
  logic       wait_load;
  ctl_t       ctl_next, ctl_out;

  // Reload on every entry into a memory state; a state that stalls on
  // itself keeps counting down instead of reloading.
  assign wait_load = is_mem_state(state_next) && (state_next != state_reg);

  mem_wait_ctr u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .dec      (is_mem_state(state_reg)),
    .load_val (WAIT_INIT),
    .done     (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      op_reg      <= 6'd0;
      funct_reg   <= 6'd0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        op_reg    <= opcode;
        funct_reg <= funct;
      end
      if ((state_reg == S_DECODE) && (state_next == S_HALT)) begin
        illegal_reg <= 1'b1;
      end
    end
  end

  // Next state. opcode/funct are consulted only in DECODE; later states use
  // the latched copy so the IR may change freely after decode.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:    if (wait_done) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_next = (ENABLE_JR && (funct == FN_JR)) ? S_JR : S_R_EXEC;
          OP_LW,
          OP_SW:    state_next = S_MEM_ADDR;
          OP_ADDI,
          OP_ANDI:  state_next = S_I_EXEC;
          OP_BEQ,
          OP_BNE:   state_next = S_BRANCH;
          OP_J:     state_next = S_JUMP;
          OP_JAL:   state_next = S_JAL;
          default:  state_next = S_HALT;
        endcase
      end
      S_MEM_ADDR: state_next = (op_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (wait_done) state_next = S_MEM_WB;
      S_MEM_WB:   state_next = S_FETCH;
      S_MEM_WR:   if (wait_done) state_next = S_FETCH;
      S_R_EXEC:   state_next = S_R_WB;
      S_R_WB:     state_next = S_FETCH;
      S_I_EXEC:   state_next = S_I_WB;
      S_I_WB:     state_next = S_FETCH;
      S_BRANCH,
      S_JUMP,
      S_JAL,
      S_JR:       state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_FETCH;
    endcase
  end

  // Moore output decode from the registered state and latched IR fields.
  always_comb begin
    ctl_next = '0;
    case (state_reg)
      S_FETCH: begin
        ctl_next.mem_read  = 1'b1;
        ctl_next.alu_src_b = ALUSRCB_FOUR;
        ctl_next.alu_op    = ALUOP_ADD;
        ctl_next.pc_source = PCSRC_ALU;
        // IR and PC only commit once the memory word is actually there
        ctl_next.ir_write  = wait_done;
        ctl_next.pc_write  = wait_done;
      end
      S_DECODE: begin
        ctl_next.alu_src_b = ALUSRCB_IMM_SH2;
        ctl_next.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctl_next.alu_src_a = 1'b1;
        ctl_next.alu_src_b = ALUSRCB_IMM;
        ctl_next.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctl_next.mem_read = 1'b1;
        ctl_next.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctl_next.reg_write  = 1'b1;
        ctl_next.reg_dst    = REGDST_RT;
        ctl_next.mem_to_reg = MEMTOREG_MDR;
      end
      S_MEM_WR: begin
        ctl_next.iord      = 1'b1;
        // single write pulse at the end of the window
        ctl_next.mem_write = wait_done;
      end
      S_R_EXEC: begin
        ctl_next.alu_src_a = 1'b1;
        ctl_next.alu_src_b = ALUSRCB_RT;
        ctl_next.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctl_next.reg_write  = 1'b1;
        ctl_next.reg_dst    = REGDST_RD;
        ctl_next.mem_to_reg = MEMTOREG_ALUOUT;
      end
      S_I_EXEC: begin
        ctl_next.alu_src_a = 1'b1;
        ctl_next.alu_src_b = ALUSRCB_IMM;
        ctl_next.alu_op    = (op_reg == OP_ANDI) ? ALUOP_ANDI : ALUOP_ADD;
      end
      S_I_WB: begin
        ctl_next.reg_write  = 1'b1;
        ctl_next.reg_dst    = REGDST_RT;
        ctl_next.mem_to_reg = MEMTOREG_ALUOUT;
      end
      S_BRANCH: begin
        ctl_next.alu_src_a     = 1'b1;
        ctl_next.alu_src_b     = ALUSRCB_RT;
        ctl_next.alu_op        = ALUOP_SUB;
        ctl_next.pc_write_cond = 1'b1;
        ctl_next.pc_source     = PCSRC_ALUOUT;
        ctl_next.branch_not    = (op_reg == OP_BNE);
      end
      S_JUMP: begin
        ctl_next.pc_write  = 1'b1;
        ctl_next.pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        ctl_next.pc_write   = 1'b1;
        ctl_next.pc_source  = PCSRC_JUMP;
        ctl_next.reg_write  = 1'b1;
        ctl_next.reg_dst    = REGDST_RA;
        ctl_next.mem_to_reg = MEMTOREG_PC;
      end
      S_JR: begin
        // JR is only reachable with this funct latched; the guard keeps a
        // corrupted latch from steering the PC to rs.
        ctl_next.pc_write  = (funct_reg == FN_JR);
        ctl_next.pc_source = PCSRC_RS;
      end
      default: ;
    endcase
  end

  // Reset blanks every strobe immediately, so an aborted instruction cannot
  // issue a write in the cycle reset is raised.
  assign ctl_out = reset ? '0 : ctl_next;

  assign PCWrite     = ctl_out.pc_write;
  assign PCWriteCond = ctl_out.pc_write_cond;
  assign BranchNot   = ctl_out.branch_not;
  assign IorD        = ctl_out.iord;
  assign MemRead     = ctl_out.mem_read;
  assign MemWrite    = ctl_out.mem_write;
  assign IRWrite     = ctl_out.ir_write;
  assign RegDst      = ctl_out.reg_dst;
  assign MemToReg    = ctl_out.mem_to_reg;
  assign RegWrite    = ctl_out.reg_write;
  assign ALUSrcA     = ctl_out.alu_src_a;
  assign ALUSrcB     = ctl_out.alu_src_b;
  assign ALUOp       = ctl_out.alu_op;
  assign PCSource    = ctl_out.pc_source;
  assign illegal     = illegal_reg & ~reset;
  assign state       = state_reg;

endmodule

// File: tb/tb_control_multicycle.sv
// tb_control_multicycle: four control_multicycle instances (W=0/JR, W=2,
// W=3, W=0/no JR) on one clock; the instance under test is chosen by 'sel'.
// Expected per-cycle state and strobe vectors are queued when an
// instruction is issued and popped one per cycle at the falling edge.
module tb_control_multicycle;

  localparam int NI = 4;

  function automatic int w_of(input int i);
    case (i)
      1:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic bit jr_of(input int i);
    return (i != 3);
  endfunction

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       bn;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic [1:0] rd;
    logic [2:0] m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] pcs;
    logic       ill;
  } ctl_t;

  typedef struct {
    string      tag;
    logic [3:0] st;
    ctl_t       c;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;

  logic       pcw [NI];
  logic       pcwc[NI];
  logic       bn  [NI];
  logic       iord[NI];
  logic       mr  [NI];
  logic       mw  [NI];
  logic       irw [NI];
  logic [1:0] rd  [NI];
  logic [2:0] m2r [NI];
  logic       rw  [NI];
  logic       asa [NI];
  logic [1:0] asb [NI];
  logic [1:0] aop [NI];
  logic [1:0] pcs [NI];
  logic       ill [NI];
  logic [3:0] st_o[NI];
  ctl_t       ctl_o[NI];

  int   sel = 0;
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    control_multicycle #(
      .MEM_WAIT  (w_of(gi)),
      .ENABLE_JR (jr_of(gi))
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .PCWrite     (pcw[gi]),
      .PCWriteCond (pcwc[gi]),
      .BranchNot   (bn[gi]),
      .IorD        (iord[gi]),
      .MemRead     (mr[gi]),
      .MemWrite    (mw[gi]),
      .IRWrite     (irw[gi]),
      .RegDst      (rd[gi]),
      .MemToReg    (m2r[gi]),
      .RegWrite    (rw[gi]),
      .ALUSrcA     (asa[gi]),
      .ALUSrcB     (asb[gi]),
      .ALUOp       (aop[gi]),
      .PCSource    (pcs[gi]),
      .illegal     (ill[gi]),
      .state       (st_o[gi])
    );
    assign ctl_o[gi] = {pcw[gi], pcwc[gi], bn[gi], iord[gi], mr[gi], mw[gi], irw[gi],
                        rd[gi], m2r[gi], rw[gi], asa[gi], asb[gi], aop[gi], pcs[gi], ill[gi]};
  end

  // Reference strobe table for one state; 'last' marks the final cycle of a
  // memory wait window.
  function automatic ctl_t exp_ctl(input logic [3:0] s, input logic [5:0] op, input logic last);
    ctl_t c;
    c = '0;
    case (s)
      4'd0:  begin c.mr = 1'b1; c.asb = 2'b01; c.irw = last; c.pcw = last; end
      4'd1:  begin c.asb = 2'b11; end
      4'd2:  begin c.asa = 1'b1; c.asb = 2'b10; end
      4'd3:  begin c.mr = 1'b1; c.iord = 1'b1; end
      4'd4:  begin c.rw = 1'b1; c.m2r = 3'b001; end
      4'd5:  begin c.iord = 1'b1; c.mw = last; end
      4'd6:  begin c.asa = 1'b1; c.aop = 2'b10; end
      4'd7:  begin c.rw = 1'b1; c.rd = 2'b01; end
      4'd8:  begin c.asa = 1'b1; c.asb = 2'b10; c.aop = (op == 6'b001100) ? 2'b11 : 2'b00; end
      4'd9:  begin c.rw = 1'b1; end
      4'd10: begin c.asa = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01;
                   c.bn = (op == 6'b000101); end
      4'd11: begin c.pcw = 1'b1; c.pcs = 2'b10; end
      4'd12: begin c.pcw = 1'b1; c.pcs = 2'b10; c.rw = 1'b1; c.rd = 2'b10; c.m2r = 3'b010; end
      4'd13: begin c.pcw = 1'b1; c.pcs = 2'b11; end
      4'd14: begin c.ill = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk_st(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s state: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_ctl(input string tag, input ctl_t obs, input ctl_t expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      err_cnt++;
      $error("FAIL %s ctl: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Queue the expected cycle-by-cycle trace of one instruction. limit>0
  // truncates the trace (used when the instruction is aborted by reset).
  task automatic push_instr(input int w, input bit jr_en, input logic [5:0] op,
                            input logic [5:0] fn, input string tag, input int limit);
    logic [3:0] path[$];
    int         reps;
    exp_t       e;
    path = {};
    path.push_back(4'd0);
    path.push_back(4'd1);
    case (op)
      6'b000000: begin
        if (jr_en && (fn == 6'b001000)) path.push_back(4'd13);
        else begin path.push_back(4'd6); path.push_back(4'd7); end
      end
      6'b100011: begin path.push_back(4'd2); path.push_back(4'd3); path.push_back(4'd4); end
      6'b101011: begin path.push_back(4'd2); path.push_back(4'd5); end
      6'b001000,
      6'b001100: begin path.push_back(4'd8); path.push_back(4'd9); end
      6'b000100,
      6'b000101: path.push_back(4'd10);
      6'b000010: path.push_back(4'd11);
      6'b000011: path.push_back(4'd12);
      default:   for (int k = 0; k < 10; k++) path.push_back(4'd14);
    endcase
    foreach (path[i]) begin
      reps = (path[i] == 4'd0 || path[i] == 4'd3 || path[i] == 4'd5) ? w + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        if (limit == 0 || sb.size() < limit) begin
          e.tag = tag;
          e.st  = path[i];
          e.c   = exp_ctl(path[i], op, (r == reps - 1));
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic drain(input int s);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      chk_st(e.tag, st_o[s], e.st);
      chk_ctl(e.tag, ctl_o[s], e.c);
      $display("inst=%0d %s cyc=%0d state=%0d ctl=%h", s, e.tag, cyc, st_o[s], ctl_o[s]);
      cyc++;
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input string tag, input int limit);
    opcode = op;
    funct  = fn;
    push_instr(w_of(sel), jr_of(sel), op, fn, tag, limit);
    drain(sel);
  endtask

  // Raise reset at a falling edge (strobes must blank at once), hold it over
  // two rising edges, release just after the second.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_ctl({tag, "_force"}, ctl_o[sel], '0);
    @(negedge clk);
    chk_st({tag, "_state"}, st_o[sel], 4'd0);
    chk_ctl({tag, "_zero"}, ctl_o[sel], '0);
    $display("inst=%0d %s reset state=%0d ctl=%h", sel, tag, st_o[sel], ctl_o[sel]);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", cmp_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    // W=0, JR enabled
    sel = 0;
    do_reset("rst0");
    run(6'b000000, 6'b100000, "r_add",  0);
    run(6'b000000, 6'b001000, "jr",     0);
    run(6'b000100, 6'b000000, "beq",    0);
    run(6'b000101, 6'b000000, "bne",    0);
    run(6'b000010, 6'b000000, "j",      0);
    run(6'b000011, 6'b000000, "jal",    0);
    run(6'b001000, 6'b000000, "addi",   0);
    run(6'b001100, 6'b000000, "andi",   0);
    run(6'b100011, 6'b000000, "lw_w0",  0);
    run(6'b101011, 6'b000000, "sw_w0",  0);
    run(6'b111111, 6'b000000, "illegal", 0);
    do_reset("rst_halt");
    run(6'b000000, 6'b100000, "r_after_halt", 0);

    // W=0, JR disabled: funct 001000 is an ordinary R-type
    sel = 3;
    do_reset("rst3");
    run(6'b000000, 6'b001000, "r_nojr", 0);

    // W=2
    sel = 1;
    do_reset("rst1");
    run(6'b100011, 6'b000000, "lw_w2",  0);
    run(6'b101011, 6'b000000, "sw_w2",  0);
    run(6'b000101, 6'b000000, "bne_w2", 0);

    // W=3: reset lands in MEM_WR before its last cycle
    sel = 2;
    do_reset("rst2");
    run(6'b101011, 6'b000000, "sw_abort", 8);
    do_reset("rst_abort");
    run(6'b000000, 6'b100000, "r_w3", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
